// File: rtl/rob_pkg.sv
// Shared widths and per-entry metadata for the reorder buffer.
package rob_pkg;

   localparam int ROB_DATA_WIDTH = 32;
   localparam int ROB_TAG_WIDTH  = 7;
   localparam int ROB_RF_WIDTH   = 5;

   typedef struct packed {
      logic                    busy;
      logic                    done;
      logic                    has_rd;
      logic [ROB_RF_WIDTH-1:0] rd;
   } rob_meta_t;

   // x0 is hardwired, so an entry only writes the register file with a non-zero rd
   function automatic logic rob_writes_rf(input rob_meta_t m);
      return m.has_rd && (m.rd != {ROB_RF_WIDTH{1'b0}});
   endfunction

endpackage

// File: rtl/rob_data_ram.sv
// Result storage: written by writeback, read asynchronously at the head entry.
module rob_data_ram
   import rob_pkg::*;
#(
   parameter int DATA_WIDTH = ROB_DATA_WIDTH,
   parameter int ADDR_WIDTH = ROB_TAG_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Write port; no reset so the array can map onto RAM macros
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: issues tags at dispatch, collects results by tag,
// and retires them in program order onto the register-file write port.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DATA_WIDTH = ROB_DATA_WIDTH,
   parameter int TAG_WIDTH  = ROB_TAG_WIDTH,
   parameter int RF_WIDTH   = ROB_RF_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  halt,
   input  logic                  flush,
   input  logic                  alloc_valid,
   input  logic                  alloc_has_rd,
   input  logic [RF_WIDTH-1:0]   alloc_rd,
   output logic                  alloc_ready,
   output logic [TAG_WIDTH-1:0]  alloc_tag,
   input  logic                  wb_valid,
   input  logic [TAG_WIDTH-1:0]  wb_tag,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  commit_valid,
   output logic                  commit_we,
   output logic [RF_WIDTH-1:0]   commit_rd,
   output logic [TAG_WIDTH-1:0]  commit_tag,
   output logic [DATA_WIDTH-1:0] commit_data,
   output logic [TAG_WIDTH:0]    occupancy
);

   localparam int               DEPTH   = 1 << TAG_WIDTH;
   localparam logic [TAG_WIDTH:0] PTR_ZERO = {(TAG_WIDTH+1){1'b0}};
   localparam logic [TAG_WIDTH:0] PTR_ONE  = {{TAG_WIDTH{1'b0}}, 1'b1};

   // Pointers carry an extra wrap bit so full and empty are distinguishable
   logic [TAG_WIDTH:0]     head_r;
   logic [TAG_WIDTH:0]     tail_r;
   rob_meta_t              meta_r [DEPTH];

   logic [TAG_WIDTH-1:0]   head_idx_s;
   logic [TAG_WIDTH-1:0]   tail_idx_s;
   rob_meta_t              head_meta_s;
   logic [DATA_WIDTH-1:0]  head_data_s;
   logic                   empty_s;
   logic                   full_s;
   logic                   alloc_fire_s;
   logic                   wb_fire_s;
   logic                   commit_fire_s;

   // Occupancy flags and per-cycle action decisions; flush suppresses all of them
   always_comb begin
      head_idx_s    = head_r[TAG_WIDTH-1:0];
      tail_idx_s    = tail_r[TAG_WIDTH-1:0];
      head_meta_s   = meta_r[head_idx_s];
      empty_s       = (head_r == tail_r);
      full_s        = (head_idx_s == tail_idx_s) && (head_r[TAG_WIDTH] != tail_r[TAG_WIDTH]);
      alloc_fire_s  = alloc_valid && !full_s && !flush;
      wb_fire_s     = wb_valid && meta_r[wb_tag].busy && !flush;
      commit_fire_s = !empty_s && head_meta_s.busy && head_meta_s.done && !halt && !flush;
   end

   assign alloc_ready = !full_s;
   assign alloc_tag   = tail_idx_s;
   assign occupancy   = tail_r - head_r;

   // Head/tail pointer update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_r <= PTR_ZERO;
         tail_r <= PTR_ZERO;
      end else if (flush) begin
         head_r <= PTR_ZERO;
         tail_r <= PTR_ZERO;
      end else begin
         if (alloc_fire_s) begin
            tail_r <= tail_r + PTR_ONE;
         end
         if (commit_fire_s) begin
            head_r <= head_r + PTR_ONE;
         end
      end
   end

   // Entry metadata; retirement is applied after writeback so a retiring entry ends idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            meta_r[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            meta_r[i] <= '0;
         end
      end else begin
         if (wb_fire_s) begin
            meta_r[wb_tag].done <= 1'b1;
         end
         if (commit_fire_s) begin
            meta_r[head_idx_s].busy <= 1'b0;
            meta_r[head_idx_s].done <= 1'b0;
         end
         if (alloc_fire_s) begin
            meta_r[tail_idx_s] <= '{busy: 1'b1, done: 1'b0, has_rd: alloc_has_rd, rd: alloc_rd};
         end
      end
   end

   rob_data_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (TAG_WIDTH)
   ) u_data_ram (
      .clk   (clk),
      .we    (wb_fire_s),
      .waddr (wb_tag),
      .wdata (wb_data),
      .raddr (head_idx_s),
      .rdata (head_data_s)
   );

   // Registered commit port; everything but the valid pulse holds until the next retirement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_valid <= 1'b0;
         commit_we    <= 1'b0;
         commit_rd    <= {RF_WIDTH{1'b0}};
         commit_tag   <= {TAG_WIDTH{1'b0}};
         commit_data  <= {DATA_WIDTH{1'b0}};
      end else if (commit_fire_s) begin
         commit_valid <= 1'b1;
         commit_we    <= rob_writes_rf(head_meta_s);
         commit_rd    <= head_meta_s.rd;
         commit_tag   <= head_idx_s;
         commit_data  <= head_data_s;
      end else begin
         commit_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

   localparam int DW = 32;
   localparam int TW = 7;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          halt;
   logic          flush;
   logic          alloc_valid;
   logic          alloc_has_rd;
   logic [RW-1:0] alloc_rd;
   logic          alloc_ready;
   logic [TW-1:0] alloc_tag;
   logic          wb_valid;
   logic [TW-1:0] wb_tag;
   logic [DW-1:0] wb_data;
   logic          commit_valid;
   logic          commit_we;
   logic [RW-1:0] commit_rd;
   logic [TW-1:0] commit_tag;
   logic [DW-1:0] commit_data;
   logic [TW:0]   occupancy;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   reorder_buffer #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .RF_WIDTH(RW)) dut (
      .clk          (clk),
      .rst          (rst),
      .halt         (halt),
      .flush        (flush),
      .alloc_valid  (alloc_valid),
      .alloc_has_rd (alloc_has_rd),
      .alloc_rd     (alloc_rd),
      .alloc_ready  (alloc_ready),
      .alloc_tag    (alloc_tag),
      .wb_valid     (wb_valid),
      .wb_tag       (wb_tag),
      .wb_data      (wb_data),
      .commit_valid (commit_valid),
      .commit_we    (commit_we),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_tag),
      .commit_data  (commit_data),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic has_rd, input logic [RW-1:0] rd);
      alloc_valid  = 1'b1;
      alloc_has_rd = has_rd;
      alloc_rd     = rd;
      step();
      alloc_valid  = 1'b0;
   endtask

   task automatic wb(input logic [TW-1:0] tag, input logic [DW-1:0] data);
      wb_valid = 1'b1;
      wb_tag   = tag;
      wb_data  = data;
      step();
      wb_valid = 1'b0;
   endtask

   task automatic check_commit(input string tag, input logic [TW-1:0] t, input logic [RW-1:0] rd,
                               input logic we, input logic [DW-1:0] data);
      check_eq({tag, "_valid"}, commit_valid, 1'b1);
      check_eq({tag, "_tag"},   commit_tag, t);
      check_eq({tag, "_rd"},    commit_rd, rd);
      check_eq({tag, "_we"},    commit_we, we);
      check_eq({tag, "_data"},  commit_data, data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; halt = 1'b0; flush = 1'b0;
      alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = '0;
      wb_valid = 1'b0; wb_tag = '0; wb_data = '0;

      // reset
      repeat (3) step();
      check_eq("rst_ready", alloc_ready, 1'b1);
      check_eq("rst_cvalid", commit_valid, 1'b0);
      rst = 1'b1;
      step();
      check_eq("post_rst_ready", alloc_ready, 1'b1);
      check_eq("post_rst_occ", occupancy, 8'd0);
      check_eq("post_rst_tag", alloc_tag, 7'd0);
      check_eq("post_rst_cvalid", commit_valid, 1'b0);
      check_eq("post_rst_cdata", commit_data, 32'd0);

      // in-order retirement with out-of-order writeback and data overwrite
      check_eq("a0_tag", alloc_tag, 7'd0);
      alloc(1'b1, 5'd5);
      check_eq("a1_tag", alloc_tag, 7'd1);
      alloc(1'b1, 5'd6);
      wb(7'd1, 32'h55);
      wb(7'd1, 32'hBB);
      wb(7'd0, 32'hAA);
      check_eq("order_occ", occupancy, 8'd2);
      check_eq("order_latency", commit_valid, 1'b0);
      step();
      check_commit("c0", 7'd0, 5'd5, 1'b1, 32'hAA);
      step();
      check_commit("c1", 7'd1, 5'd6, 1'b1, 32'hBB);
      step();
      check_eq("order_pulse", commit_valid, 1'b0);
      check_eq("order_hold_tag", commit_tag, 7'd1);
      check_eq("order_hold_data", commit_data, 32'hBB);
      check_eq("order_empty", occupancy, 8'd0);

      // fill to full, commit while allocation is requested
      flush = 1'b1; step(); flush = 1'b0;
      for (int i = 0; i < 128; i++) alloc(1'b1, 5'd3);
      check_eq("full_ready", alloc_ready, 1'b0);
      check_eq("full_occ", occupancy, 8'd128);
      wb(7'd0, 32'h1234);
      alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd9;
      check_eq("full_block", alloc_ready, 1'b0);
      step();
      check_commit("cfull", 7'd0, 5'd3, 1'b1, 32'h1234);
      check_eq("full_occ_after", occupancy, 8'd127);
      check_eq("full_ready_after", alloc_ready, 1'b1);
      check_eq("wrap_tag", alloc_tag, 7'd0);
      step();
      alloc_valid = 1'b0;
      check_eq("refill_occ", occupancy, 8'd128);
      check_eq("refill_ready", alloc_ready, 1'b0);
      check_eq("refill_cvalid", commit_valid, 1'b0);
      flush = 1'b1; step(); flush = 1'b0;
      check_eq("drain_occ", occupancy, 8'd0);

      // no-destination and rd==0 entries retire without a write
      alloc(1'b0, 5'd9);
      alloc(1'b1, 5'd0);
      wb(7'd0, 32'h11);
      wb(7'd1, 32'h22);
      check_commit("nord", 7'd0, 5'd9, 1'b0, 32'h11);
      step();
      check_commit("rd0", 7'd1, 5'd0, 1'b0, 32'h22);
      step();
      check_eq("nowe_pulse", commit_valid, 1'b0);

      // halt holds three done entries
      halt = 1'b1;
      alloc(1'b1, 5'd1);
      alloc(1'b1, 5'd2);
      alloc(1'b1, 5'd3);
      wb(7'd2, 32'h301);
      wb(7'd3, 32'h302);
      wb(7'd4, 32'h303);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("halt_cvalid", commit_valid, 1'b0);
      end
      check_eq("halt_occ", occupancy, 8'd3);
      halt = 1'b0;
      step();
      check_commit("h0", 7'd2, 5'd1, 1'b1, 32'h301);
      step();
      check_commit("h1", 7'd3, 5'd2, 1'b1, 32'h302);
      step();
      check_commit("h2", 7'd4, 5'd3, 1'b1, 32'h303);
      step();
      check_eq("halt_end_pulse", commit_valid, 1'b0);
      check_eq("halt_end_occ", occupancy, 8'd0);

      // flush with concurrent alloc and writeback, then stale writeback
      flush = 1'b1; step(); flush = 1'b0;
      halt = 1'b1;
      alloc(1'b1, 5'd10);
      alloc(1'b1, 5'd11);
      alloc(1'b1, 5'd12);
      alloc(1'b1, 5'd13);
      wb(7'd0, 32'h600);
      wb(7'd1, 32'h601);
      check_eq("preflush_occ", occupancy, 8'd4);
      flush = 1'b1; alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd14;
      wb_valid = 1'b1; wb_tag = 7'd3; wb_data = 32'h6FF;
      step();
      flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; halt = 1'b0;
      check_eq("flush_occ", occupancy, 8'd0);
      check_eq("flush_tag", alloc_tag, 7'd0);
      check_eq("flush_ready", alloc_ready, 1'b1);
      check_eq("flush_cvalid", commit_valid, 1'b0);
      wb(7'd2, 32'hDEAD);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stale_cvalid", commit_valid, 1'b0);
         check_eq("stale_occ", occupancy, 8'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
